// File: rtl/prng_keystream_arbiter.sv
// prng_keystream_arbiter: owns a 128-bit LFSR keystream core. It sequences
// the seed load and the warm-up discard, then serves word-sized keystream
// requests from N_REQ requesters in round-robin order. Each word is packed
// MSB-first from WORD_W consecutive LFSR bits.
module prng_keystream_arbiter #(
  parameter int N_REQ  = 4,
  parameter int WORD_W = 32,
  parameter int WARMUP = 128
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [127:0]      i_seed,
  input  logic              i_seed_valid,
  output logic              o_seed_ready,
  input  logic [N_REQ-1:0]  i_req,
  output logic [N_REQ-1:0]  o_gnt,
  output logic [WORD_W-1:0] o_data,
  output logic              o_seeded,
  output logic              o_busy,
  output logic              o_lfsr_load,
  output logic [127:0]      o_lfsr_seed,
  output logic              o_lfsr_en,
  input  logic              i_lfsr_bit
);

  localparam int MAXC  = (WARMUP > WORD_W) ? WARMUP : WORD_W;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam int IDX_W = $clog2(N_REQ);

  // Terminal counts for the two stepping phases; WARM is never entered
  // when WARMUP is zero, so its terminal value is then irrelevant.
  localparam logic [CNT_W-1:0] WARM_LAST = (WARMUP > 0) ? CNT_W'(WARMUP - 1) : '0;
  localparam logic [CNT_W-1:0] GEN_LAST  = CNT_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_UNSEEDED,
    S_LOAD,
    S_WARM,
    S_IDLE,
    S_GEN,
    S_RESP
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [127:0]       seed_q;
  logic [WORD_W-1:0]  word;
  logic [WORD_W-1:0]  word_shift;
  logic [WORD_W:0]    word_cat;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   pick;
  logic               pick_vld;
  logic [N_REQ-1:0]   gnt_onehot;
  logic               seed_take;
  logic               warm_done;
  logic               gen_done;

  // New LFSR bit enters at the LSB, so the first bit ends up in the MSB.
  assign word_cat   = {word, i_lfsr_bit};
  assign word_shift = word_cat[WORD_W-1:0];
  assign gnt_onehot = N_REQ'(1) << winner;

  assign seed_take = o_seed_ready && i_seed_valid;
  assign warm_done = (state == S_WARM) && (cnt == WARM_LAST);
  assign gen_done  = (state == S_GEN)  && (cnt == GEN_LAST);

  // Round-robin pick: scan from last_grant+1, wrapping, first requester wins.
  always_comb begin : rr_pick
    logic [IDX_W-1:0] cand;
    cand     = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % N_REQ);
      if (!pick_vld && i_req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state logic; a seed in IDLE outranks any pending request.
  always_comb begin
    state_nxt = state;
    case (state)
      S_UNSEEDED: if (i_seed_valid) state_nxt = S_LOAD;
      S_LOAD:     state_nxt = (WARMUP == 0) ? S_IDLE : S_WARM;
      S_WARM:     if (warm_done) state_nxt = S_IDLE;
      S_IDLE: begin
        if (i_seed_valid)  state_nxt = S_LOAD;
        else if (pick_vld) state_nxt = S_GEN;
      end
      S_GEN:      if (gen_done) state_nxt = S_RESP;
      S_RESP:     state_nxt = S_IDLE;
      default:    state_nxt = S_UNSEEDED;
    endcase
  end

  // Control outputs decoded straight from state.
  always_comb begin
    o_seed_ready = (state == S_UNSEEDED) || (state == S_IDLE);
    o_lfsr_load  = (state == S_LOAD);
    o_lfsr_en    = (state == S_WARM) || (state == S_GEN);
    o_busy       = (state == S_LOAD) || (state == S_WARM) ||
                   (state == S_GEN)  || (state == S_RESP);
    o_lfsr_seed  = seed_q;
  end

  // State register and phase counter; the counter restarts on every state change.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_UNSEEDED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state != state_nxt) cnt <= '0;
      else if (o_lfsr_en)     cnt <= cnt + 1'b1;
    end
  end

  // Seed capture, winner tracking and word packing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seed_q     <= '0;
      word       <= '0;
      winner     <= '0;
      last_grant <= LAST_IDX;
    end else begin
      if (seed_take) seed_q <= i_seed;
      if (state == S_IDLE && !i_seed_valid && pick_vld) winner <= pick;
      if (state == S_GEN) word <= word_shift;
      if (state == S_RESP) last_grant <= winner;
    end
  end

  // Registered response: grant and word launch on the last GEN edge so they
  // are visible during RESP; o_data then holds until the next response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_gnt    <= '0;
      o_data   <= '0;
      o_seeded <= 1'b0;
    end else begin
      o_gnt <= '0;
      if (gen_done) begin
        o_gnt  <= gnt_onehot;
        o_data <= word_shift;
      end
      if (warm_done || (state == S_LOAD && WARMUP == 0)) o_seeded <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prng_keystream_arbiter.sv
// Directed bench for prng_keystream_arbiter: emulates the 128-bit LFSR core
// next to the DUT and checks words against an independent stepped model.
module tb_prng_keystream_arbiter;

  localparam int N_REQ  = 4;
  localparam int WORD_W = 32;
  localparam int WARMUP = 128;

  logic              clk;
  logic              rst_n;
  logic [127:0]      seed;
  logic              seed_valid;
  logic              seed_ready;
  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  gnt;
  logic [WORD_W-1:0] data;
  logic              seeded;
  logic              busy;
  logic              lfsr_load;
  logic [127:0]      lfsr_seed;
  logic              lfsr_en;
  logic              lfsr_bit;

  logic [127:0]      core;
  logic [127:0]      ref_s;

  int n_chk;
  int n_fail;

  prng_keystream_arbiter #(.N_REQ(N_REQ), .WORD_W(WORD_W), .WARMUP(WARMUP)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_seed       (seed),
    .i_seed_valid (seed_valid),
    .o_seed_ready (seed_ready),
    .i_req        (req),
    .o_gnt        (gnt),
    .o_data       (data),
    .o_seeded     (seeded),
    .o_busy       (busy),
    .o_lfsr_load  (lfsr_load),
    .o_lfsr_seed  (lfsr_seed),
    .o_lfsr_en    (lfsr_en),
    .i_lfsr_bit   (lfsr_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fibonacci LFSR, taps 128,126,101,99; output bit is the MSB.
  function automatic logic [127:0] lfsr_step(input logic [127:0] s);
    return {s[126:0], s[127] ^ s[125] ^ s[100] ^ s[98]};
  endfunction

  // LFSR core emulation driven by the DUT's load/step strobes.
  initial core = '0;
  always @(posedge clk) begin
    if (lfsr_load)    core <= lfsr_seed;
    else if (lfsr_en) core <= lfsr_step(core);
  end
  assign lfsr_bit = core[127];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_seed(input logic [127:0] s);
    ref_s = s;
    for (int i = 0; i < WARMUP; i++) ref_s = lfsr_step(ref_s);
  endtask

  task automatic ref_word(output logic [WORD_W-1:0] w);
    w = '0;
    for (int i = 0; i < WORD_W; i++) begin
      w = {w[WORD_W-2:0], ref_s[127]};
      ref_s = lfsr_step(ref_s);
    end
  endtask

  // Waits (bounded) for a grant pulse; cyc counts negedges until it is seen.
  task automatic wait_grant(input int bound, output logic [N_REQ-1:0] g,
                            output logic [WORD_W-1:0] d, output int cyc);
    g = '0; d = '0; cyc = 0;
    while (cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0) begin
        g = gnt;
        d = data;
        break;
      end
    end
  endtask

  initial begin
    logic [N_REQ-1:0]  g;
    logic [WORD_W-1:0] d, w;
    logic [127:0]      ld_seed;
    int cyc, loads, ens, bad_gnt, bad_en, bad_rdy;
    logic [N_REQ-1:0]  exp_g [5];
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; seed = '0; seed_valid = 1'b0; req = '0;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_gnt",    gnt, 0);
    chk("rst_data",   data, 0);
    chk("rst_seeded", seeded, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_load",   lfsr_load, 0);
    chk("rst_en",     lfsr_en, 0);
    chk("rst_lseed",  lfsr_seed, 0);
    chk("rst_ready",  seed_ready, 1);
    rst_n = 1'b1;

    // Requests before any seed are ignored
    req = 4'b0001;
    bad_gnt = 0; bad_en = 0; bad_rdy = 0;
    repeat (100) begin
      @(negedge clk);
      if (gnt != 0) bad_gnt++;
      if (lfsr_en)  bad_en++;
      if (!seed_ready) bad_rdy++;
    end
    chk("unseeded_gnt", bad_gnt, 0);
    chk("unseeded_en",  bad_en, 0);
    chk("unseeded_rdy", bad_rdy, 0);

    // Seed load and warm-up
    req = '0; seed = 128'h1; seed_valid = 1'b1;
    cyc = 0; loads = 0; ens = 0; ld_seed = '0;
    do begin
      @(negedge clk);
      cyc++;
      if (lfsr_load) begin loads++; ld_seed = lfsr_seed; end
      if (lfsr_en) ens++;
      seed_valid = 1'b0;
    end while (!seeded && cyc < 400);
    chk("seed_cycles", cyc, 130);
    chk("load_count",  loads, 1);
    chk("load_seed",   ld_seed, 128'h1);
    chk("warm_steps",  ens, WARMUP);
    chk("seeded_set",  seeded, 1);
    ref_seed(128'h1);

    // Round-robin with all requesters held
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(200, g, d, cyc);
      ref_word(w);
      chk($sformatf("rr_gnt%0d", i), g, exp_g[i]);
      chk($sformatf("rr_data%0d", i), d, w);
      chk($sformatf("rr_gap%0d", i), cyc, (i == 0) ? 33 : 34);
    end
    req = '0;

    // Seed and request together in IDLE: reload first, then grant to 2
    @(negedge clk);
    seed = 128'hDEADBEEF_01234567_89ABCDEF_F00DFACE; seed_valid = 1'b1; req = 4'b0100;
    @(negedge clk);
    chk("reseed_load",   lfsr_load, 1);
    chk("reseed_seed",   lfsr_seed, 128'hDEADBEEF_01234567_89ABCDEF_F00DFACE);
    chk("reseed_seeded", seeded, 1);
    seed_valid = 1'b0;
    ref_seed(128'hDEADBEEF_01234567_89ABCDEF_F00DFACE);
    wait_grant(400, g, d, cyc);
    ref_word(w);
    chk("reseed_gnt",  g, 4'b0100);
    chk("reseed_data", d, w);
    chk("reseed_lat",  cyc, WARMUP + WORD_W + 2);

    // Requester 1 drops mid-GEN; grant still pulses, next word continues
    req = 4'b0010;
    repeat (5) @(negedge clk);
    chk("drop_in_gen", lfsr_en, 1);
    req = '0;
    wait_grant(100, g, d, cyc);
    ref_word(w);
    chk("drop_gnt",  g, 4'b0010);
    chk("drop_data", d, w);
    @(negedge clk);
    chk("gnt_pulse", gnt, 0);
    chk("data_hold", data, w);
    req = 4'b1000;
    wait_grant(100, g, d, cyc);
    ref_word(w);
    chk("next_gnt",  g, 4'b1000);
    chk("next_data", d, w);

    // Reset mid-GEN
    req = 4'b0001;
    repeat (10) @(negedge clk);
    chk("pre_rst_en", lfsr_en, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt",    gnt, 0);
    chk("mid_rst_en",     lfsr_en, 0);
    chk("mid_rst_seeded", seeded, 0);
    chk("mid_rst_busy",   busy, 0);
    chk("mid_rst_data",   data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad_gnt = 0; bad_en = 0;
    repeat (50) begin
      @(negedge clk);
      if (gnt != 0) bad_gnt++;
      if (lfsr_en)  bad_en++;
    end
    chk("post_rst_gnt", bad_gnt, 0);
    chk("post_rst_en",  bad_en, 0);

    // New seed after reset; requester 0 has first priority again
    seed = 128'hF; seed_valid = 1'b1;
    @(negedge clk);
    seed_valid = 1'b0;
    ref_seed(128'hF);
    wait_grant(400, g, d, cyc);
    ref_word(w);
    chk("after_rst_gnt",  g, 4'b0001);
    chk("after_rst_data", d, w);
    chk("after_rst_lat",  cyc, WARMUP + WORD_W + 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prng_keystream_arbiter.md
# prng_keystream_arbiter

Controller that owns the 128-bit LFSR keystream generator and shares it between several requesters. It sequences seed loading and a warm-up discard, then serves word-sized keystream requests in round-robin order. For each request it steps the LFSR one bit per cycle and packs the bits into a word. It sits between the LFSR core and its consumers; the LFSR core runs on the same clock, gated by this block's step enable.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WORD_W, 32, keystream word width in bits (1..128)
- WARMUP, 128, LFSR steps discarded after each seed load (0 allowed)

- i_clk  input  1  clock, all logic rising-edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_seed  input  128  seed value, sampled when the seed is accepted
- i_seed_valid  input  1  seed load request
- o_seed_ready  output  1  high in UNSEEDED/IDLE; seed accepted when valid&&ready
- i_req  input  N_REQ  per-requester level request, held until its grant
- o_gnt  output  N_REQ  one-hot, single-cycle; qualifies o_data
- o_data  output  WORD_W  keystream word, valid only while o_gnt != 0
- o_seeded  output  1  high once the first warm-up completes
- o_busy  output  1  high in LOAD, WARM, GEN, RESP
- o_lfsr_load  output  1  one-cycle LFSR parallel load strobe
- o_lfsr_seed  output  128  seed presented to LFSR, valid with o_lfsr_load
- o_lfsr_en  output  1  LFSR step enable (one shift per high cycle)
- i_lfsr_bit  input  1  LFSR keystream bit of the current, pre-shift state

## Operation
- States: UNSEEDED, LOAD, WARM, IDLE, GEN, RESP. Reset enters UNSEEDED.
- UNSEEDED: i_req ignored. When i_seed_valid is high, latch i_seed and go to LOAD.
- LOAD (1 cycle): o_lfsr_load=1, o_lfsr_seed=latched seed. Next state is WARM, or IDLE if WARMUP==0.
- WARM (WARMUP cycles): o_lfsr_en=1; bits are discarded. On the last cycle set o_seeded=1 and go to IDLE.
- IDLE:
  - If i_seed_valid is high, go to LOAD (re-seed). Seed has priority over requests. o_seeded stays 1 through a re-seed.
  - Else, if any i_req bit is high, pick a winner round-robin: search starts at last_grant+1 and wraps modulo N_REQ. Register the winner and go to GEN.
- GEN (WORD_W cycles): o_lfsr_en=1. Each cycle, shift word <= {word[WORD_W-2:0], i_lfsr_bit}. The first bit ends in the MSB.
- RESP (1 cycle): o_gnt=onehot(winner), o_data=word, last_grant<=winner, then go to IDLE.
- If a requester drops i_req during GEN, the transaction still completes and the grant still pulses. The word is consumed (lost) for keystream.
- o_lfsr_en is 0 in UNSEEDED, LOAD, IDLE and RESP. o_lfsr_load is 0 outside LOAD.
- Counters are sized $clog2 of max(WARMUP, WORD_W)+1. No wrap occurs within a phase.
- Reset values: state=UNSEEDED, o_gnt=0, o_data=0, o_seeded=0, o_busy=0, o_lfsr_load=0, o_lfsr_en=0, o_lfsr_seed=0, last_grant=N_REQ-1 (so req0 has first priority).
- Asserting i_rst_n low at any time (mid-GEN, mid-WARM) forces reset values immediately. The seed is lost and a new seed load is required.

## Timing
- Seed accepted in cycle t:
  - LOAD at t+1.
  - WARM from t+2 to t+1+WARMUP.
  - o_seeded rises at edge t+2+WARMUP.
  - IDLE at t+2+WARMUP.
- Request seen in IDLE at cycle t:
  - GEN from t+1 to t+WORD_W.
  - RESP/o_gnt at t+WORD_W+1.
  - Next IDLE at t+WORD_W+2.
- A back-to-back grant to the same or another requester follows every WORD_W+2 cycles.
- o_gnt and o_data are registered outputs. o_data holds its last value after RESP.
- o_seed_ready is combinational from state.

## Test plan
- Reset, then i_req=4'b0001 with no seed -> o_gnt stays 0 and o_lfsr_en stays 0 for 100 cycles. o_seed_ready=1 throughout.
- Seed 128'h1, WARMUP=128 -> o_lfsr_load high for exactly 1 cycle carrying 128'h1. Then exactly 128 o_lfsr_en cycles, then o_seeded=1.
- After seeding, i_req=4'b1111 held -> grants 0,1,2,3,0 spaced 34 cycles apart. Each o_data equals the next 32 bits of a 128-bit reference LFSR model, MSB first, with no bits skipped or repeated.
- i_seed_valid and i_req=4'b0100 both high in IDLE -> LOAD occurs first; the grant to requester 2 follows WARMUP+WORD_W+2 cycles later.
- Requester 1 drops i_req during GEN -> o_gnt=4'b0010 still pulses. The next word served is the subsequent 32 LFSR bits.
- i_rst_n pulsed low mid-GEN -> o_gnt, o_lfsr_en and o_seeded go to 0 immediately. Requests are ignored until a new seed is loaded.
